// File: rtl/ds18b20_responder.sv
// 1-Wire slave emulating a DS18B20: presence, Skip ROM, Convert T,
// Read/Write Scratchpad. Optional CRC byte: DS18B20_RESPONDER_CRC_EN.
// Ports: CLK_10MHZ, reset (sync, high), oneWirePinIn (raw bus),
//   oneWirePinOut (0 = pull low), temperature (latched on convert end),
//   th/tl/cfg (scratchpad 2..4), convPulse (convert done), busy.
module ds18b20_responder #(
  parameter int CONV_CYCLES   = 7500000,
  parameter int RESET_CYCLES  = 4000,
  parameter int SAMPLE_CYCLES = 300,
  parameter int PRESENCE_WAIT = 300,
  parameter int PRESENCE_LEN  = 1200,
  parameter int READ_HOLD     = 300
) (
  input  logic        CLK_10MHZ,
  input  logic        reset,
  input  logic        oneWirePinIn,
  output logic        oneWirePinOut,
  input  logic [15:0] temperature,
  output logic [7:0]  th,
  output logic [7:0]  tl,
  output logic [7:0]  cfg,
  output logic        convPulse,
  output logic        busy
);

  localparam int LW = $clog2(RESET_CYCLES + 1);
  localparam int CW = $clog2(CONV_CYCLES + 1);
  localparam int HW = $clog2(READ_HOLD + 1);
  localparam int TW = $clog2(PRESENCE_WAIT + PRESENCE_LEN
                             + SAMPLE_CYCLES + 2);

  typedef enum logic [3:0] {
    IDLE, RST_WAIT, PRESENCE, ROM_CMD, FUNC_CMD,
    WRITE_SP, READ_SP, CONV, DEAD
  } state_t;

  typedef enum logic [1:0] {ARM, SAMP, WAITHI} slot_t;

  state_t state, stateN;
  slot_t  slotPh, slotN;

  logic s1, sync, sPrev;
  logic [LW-1:0] lowCnt;
  logic [TW-1:0] tmr, tmrN;
  logic [2:0] bitCnt, bitN;
  logic [7:0] shreg, shN, byteV;
  logic [1:0] wrIdx, wrN;
  logic [6:0] rdBit, rdN;
  logic drive, driveN;
  logic [HW-1:0] holdCnt, holdN;
  logic [7:0] thN, tlN, cfgN;
  logic [7:0] tempLo, tempHi, tLoN, tHiN;
  logic [CW-1:0] convCnt, convN;
  logic convDone, doneN, pulseN;
  logic [7:0] spByte, crcByte;
  logic curBit, fall, rstDet, rxState;

`ifdef DS18B20_RESPONDER_CRC_EN
  logic [7:0] crc, crcN;
  assign crcByte = crc;
`else
  assign crcByte = 8'h00;
`endif

  assign fall = sPrev & ~sync;

  // The presence pulse is our own drive, so it must not count as a reset.
  assign rstDet = ~sync && (state != PRESENCE)
                  && (lowCnt == LW'(RESET_CYCLES - 1));

  assign rxState = (state == ROM_CMD) || (state == FUNC_CMD)
                   || (state == WRITE_SP);

  assign oneWirePinOut = rstDet | ~((state == PRESENCE) | drive);

  assign busy = rstDet | ((state != IDLE) && (state != DEAD));

  always_comb begin
    spByte = 8'h00;
    unique case (rdBit[6:3])
      4'd0:    spByte = tempLo;
      4'd1:    spByte = tempHi;
      4'd2:    spByte = th;
      4'd3:    spByte = tl;
      4'd4:    spByte = cfg;
      4'd5:    spByte = 8'hFF;
      4'd6:    spByte = 8'h0C;
      4'd7:    spByte = 8'h10;
      default: spByte = crcByte;
    endcase
  end

  assign curBit = spByte[rdBit[2:0]];

  // Sync chain and low-run counter; the counter saturates so a long
  // reset pulse is detected exactly once.
  always_ff @(posedge CLK_10MHZ) begin
    if (reset) begin
      s1     <= 1'b1;
      sync   <= 1'b1;
      sPrev  <= 1'b1;
      lowCnt <= '0;
    end else begin
      s1    <= oneWirePinIn;
      sync  <= s1;
      sPrev <= sync;
      if (sync || state == PRESENCE)
        lowCnt <= '0;
      else if (lowCnt != LW'(RESET_CYCLES))
        lowCnt <= lowCnt + 1'b1;
    end
  end

  always_ff @(posedge CLK_10MHZ) begin
    if (reset) begin
      state     <= IDLE;
      slotPh    <= ARM;
      tmr       <= '0;
      bitCnt    <= '0;
      shreg     <= '0;
      wrIdx     <= '0;
      rdBit     <= '0;
      drive     <= 1'b0;
      holdCnt   <= '0;
      th        <= 8'h4B;
      tl        <= 8'h46;
      cfg       <= 8'h7F;
      tempLo    <= 8'h50;
      tempHi    <= 8'h05;
      convCnt   <= '0;
      convDone  <= 1'b0;
      convPulse <= 1'b0;
`ifdef DS18B20_RESPONDER_CRC_EN
      crc       <= 8'h00;
`endif
    end else begin
      state     <= stateN;
      slotPh    <= slotN;
      tmr       <= tmrN;
      bitCnt    <= bitN;
      shreg     <= shN;
      wrIdx     <= wrN;
      rdBit     <= rdN;
      drive     <= driveN;
      holdCnt   <= holdN;
      th        <= thN;
      tl        <= tlN;
      cfg       <= cfgN;
      tempLo    <= tLoN;
      tempHi    <= tHiN;
      convCnt   <= convN;
      convDone  <= doneN;
      convPulse <= pulseN;
`ifdef DS18B20_RESPONDER_CRC_EN
      crc       <= crcN;
`endif
    end
  end

  always_comb begin
    stateN = state;
    slotN  = slotPh;
    tmrN   = tmr;
    bitN   = bitCnt;
    shN    = shreg;
    wrN    = wrIdx;
    rdN    = rdBit;
    driveN = drive;
    holdN  = holdCnt;
    thN    = th;
    tlN    = tl;
    cfgN   = cfg;
    tLoN   = tempLo;
    tHiN   = tempHi;
    convN  = convCnt;
    doneN  = convDone;
    pulseN = 1'b0;
    byteV  = {sync, shreg[7:1]};
`ifdef DS18B20_RESPONDER_CRC_EN
    crcN   = crc;
`endif

    if (drive) begin
      if (holdCnt == HW'(READ_HOLD - 1))
        driveN = 1'b0;
      else
        holdN = holdCnt + 1'b1;
    end

    if (state == CONV && !convDone) begin
      if (convCnt == CW'(CONV_CYCLES - 1)) begin
        doneN  = 1'b1;
        pulseN = 1'b1;
        tLoN   = temperature[7:0];
        tHiN   = temperature[15:8];
      end else begin
        convN = convCnt + 1'b1;
      end
    end

    unique case (state)
      RST_WAIT: begin
        if (!sync)
          tmrN = '0;
        else if (tmr == TW'(PRESENCE_WAIT)) begin
          stateN = PRESENCE;
          tmrN   = '0;
        end else
          tmrN = tmr + 1'b1;
      end
      PRESENCE: begin
        if (tmr == TW'(PRESENCE_LEN - 1)) begin
          stateN = ROM_CMD;
          tmrN   = '0;
          slotN  = ARM;
          bitN   = '0;
        end else
          tmrN = tmr + 1'b1;
      end
      READ_SP: begin
        if (fall) begin
          if (!curBit) begin
            driveN = 1'b1;
            holdN  = '0;
          end
`ifdef DS18B20_RESPONDER_CRC_EN
          // Bytes 0..7 stream through the CRC; byte 8 then reads it.
          if (!rdBit[6])
            crcN = {1'b0, crc[7:1]}
                   ^ ((crc[0] ^ curBit) ? 8'h8C : 8'h00);
`endif
          rdN = rdBit + 7'd1;
          if (rdBit == 7'd71)
            stateN = DEAD;
        end
      end
      CONV: begin
        if (fall && !convDone) begin
          driveN = 1'b1;
          holdN  = '0;
        end
      end
      default: ;
    endcase

    if (rxState) begin
      unique case (slotPh)
        ARM: begin
          if (fall) begin
            slotN = SAMP;
            tmrN  = '0;
          end
        end
        SAMP: begin
          if (tmr == TW'(SAMPLE_CYCLES - 1)) begin
            shN   = byteV;
            bitN  = bitCnt + 3'd1;
            slotN = WAITHI;
            if (bitCnt == 3'd7) begin
              if (state == ROM_CMD) begin
                stateN = (byteV == 8'hCC) ? FUNC_CMD : DEAD;
              end else if (state == FUNC_CMD) begin
                unique case (1'b1)
                  (byteV == 8'h44): begin
                    stateN = CONV;
                    convN  = '0;
                    doneN  = 1'b0;
                  end
                  (byteV == 8'hBE): begin
                    stateN = READ_SP;
                    rdN    = '0;
`ifdef DS18B20_RESPONDER_CRC_EN
                    crcN   = 8'h00;
`endif
                  end
                  (byteV == 8'h4E): begin
                    stateN = WRITE_SP;
                    wrN    = '0;
                  end
                  default: stateN = DEAD;
                endcase
              end else begin
                unique case (wrIdx)
                  2'd0: thN = byteV;
                  2'd1: tlN = byteV;
                  default: begin
                    cfgN   = byteV;
                    stateN = DEAD;
                  end
                endcase
                wrN = wrIdx + 2'd1;
              end
            end
          end else
            tmrN = tmr + 1'b1;
        end
        WAITHI: begin
          if (sync)
            slotN = ARM;
        end
        default: slotN = ARM;
      endcase
    end

    // A bus reset aborts everything, including a running conversion.
    if (rstDet) begin
      stateN = RST_WAIT;
      tmrN   = '0;
      slotN  = ARM;
      bitN   = '0;
      driveN = 1'b0;
      holdN  = '0;
      pulseN = 1'b0;
      tLoN   = tempLo;
      tHiN   = tempHi;
      doneN  = convDone;
    end
  end

endmodule

// File: tb/tb_ds18b20_responder.sv
// Bench for ds18b20_responder: acts as a 1-Wire master on a wired-AND
// bus and compares against a byte-level scratchpad model.
module tb_ds18b20_responder;

  localparam int CONV = 1000;
  localparam int RST  = 200;
  localparam int SMP  = 15;
  localparam int PW   = 15;
  localparam int PL   = 60;
  localparam int RH   = 15;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mLow = 1'b0;
  logic [15:0] temperature = 16'h0191;
  logic pinOut, bus, convPulse, busy;
  logic [7:0] th, tl, cfg;

  assign bus = ~mLow & pinOut;

  ds18b20_responder #(
    .CONV_CYCLES(CONV), .RESET_CYCLES(RST), .SAMPLE_CYCLES(SMP),
    .PRESENCE_WAIT(PW), .PRESENCE_LEN(PL), .READ_HOLD(RH)
  ) dut (
    .CLK_10MHZ(clk), .reset(reset), .oneWirePinIn(bus),
    .oneWirePinOut(pinOut), .temperature(temperature),
    .th(th), .tl(tl), .cfg(cfg),
    .convPulse(convPulse), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pulseCnt = 0;
  int pulseCyc = -1;
  int slotA = 0;
  logic watch = 1'b0;
  logic lowSeen = 1'b0;
  logic [7:0] sp [0:8];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (convPulse) begin
      pulseCnt <= pulseCnt + 1;
      pulseCyc <= cyc;
    end
    if (watch && !pinOut) lowSeen <= 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] dallasCrc();
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < 8; i++)
      for (int b = 0; b < 8; b++) begin
        logic mix;
        mix = c[0] ^ sp[i][b];
        c = c >> 1;
        if (mix) c = c ^ 8'h8C;
      end
    return c;
  endfunction

  task automatic fixCrc();
`ifdef DS18B20_RESPONDER_CRC_EN
    sp[8] = dallasCrc();
`else
    sp[8] = 8'h00;
`endif
  endtask

  task automatic busReset();
    mLow = 1'b1;
    clks(100);
    check("rstReleased", pinOut, 1);
    clks(140);
    check("busyRst", busy, 1);
    mLow = 1'b0;
    repeat (PW + 2) @(posedge clk);
    #1 check("preBefore", pinOut, 1);
    @(posedge clk);
    #1 check("preStart", pinOut, 0);
    check("busyPre", busy, 1);
    repeat (PL - 1) @(posedge clk);
    #1 check("preLast", pinOut, 0);
    @(posedge clk);
    #1 check("preRel", pinOut, 1);
    clks(10);
  endtask

  task automatic wbyte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      slotA = cyc + 1;
      mLow = 1'b1;
      clks(b[i] ? 5 : 40);
      mLow = 1'b0;
      clks(b[i] ? 45 : 10);
    end
  endtask

  task automatic rbit(output logic v);
    slotA = cyc + 1;
    mLow = 1'b1;
    clks(5);
    mLow = 1'b0;
    clks(7);
    v = bus;
    clks(38);
  endtask

  task automatic rbyte(output logic [7:0] b);
    logic v;
    for (int i = 0; i < 8; i++) begin
      rbit(v);
      b[i] = v;
    end
  endtask

  task automatic readCheck(input string tag);
    logic [7:0] v;
    wbyte(8'hCC);
    wbyte(8'hBE);
    for (int k = 0; k < 9; k++) begin
      rbyte(v);
      check($sformatf("%s[%0d]", tag, k), v, sp[k]);
    end
  endtask

  initial begin
    logic [7:0] gold [0:9];
    logic [7:0] v, w0, w1, w2, badCmd;
    logic b;
    int e, d, f, p0;

    gold = '{8'h50, 8'h05, 8'h4B, 8'h46, 8'h7F,
             8'hFF, 8'h0C, 8'h10, 8'h1C, 8'h00};
    sp = '{8'h50, 8'h05, 8'h4B, 8'h46, 8'h7F,
           8'hFF, 8'h0C, 8'h10, 8'h00};
    fixCrc();

    clks(5);
    check("rstOut", pinOut, 1);
    check("rstBusy", busy, 0);
    check("rstPulse", convPulse, 0);
    check("rstTh", th, 8'h4B);
    check("rstTl", tl, 8'h46);
    check("rstCfg", cfg, 8'h7F);
    reset = 1'b0;
    clks(5);
    check("idleBusy", busy, 0);

    busReset();
    wbyte(8'hCC);
    wbyte(8'hBE);
    for (int k = 0; k < 9; k++) begin
      rbyte(v);
`ifdef DS18B20_RESPONDER_CRC_EN
      check($sformatf("por[%0d]", k), v, gold[k]);
`else
      check($sformatf("por[%0d]", k), v, (k == 8) ? gold[9] : gold[k]);
`endif
    end
    check("deadBusy", busy, 0);

    for (int it = 0; it < 3; it++) begin
      if (it == 0) begin
        w0 = 8'h11; w1 = 8'h22; w2 = 8'h3F;
      end else begin
        w0 = 8'($urandom); w1 = 8'($urandom); w2 = 8'($urandom);
      end
      busReset();
      wbyte(8'hCC);
      wbyte(8'h4E);
      wbyte(w0);
      wbyte(w1);
      wbyte(w2);
      clks(2);
      check("wrTh", th, w0);
      check("wrTl", tl, w1);
      check("wrCfg", cfg, w2);
      sp[2] = w0; sp[3] = w1; sp[4] = w2;
      fixCrc();
      busReset();
      readCheck("wrRd");
    end

    temperature = 16'h0191;
    p0 = pulseCnt;
    busReset();
    wbyte(8'hCC);
    wbyte(8'h44);
    e = slotA + 2 + SMP;
    d = e + CONV;
    while (cyc < d + 300) begin
      rbit(b);
      f = slotA + 2;
      if (f < d - 1)
        check("convBusy", b, 0);
      else if (f > d + 1)
        check("convDone", b, 1);
    end
    check("pulseCnt", pulseCnt, p0 + 1);
    check("pulseCyc", pulseCyc, d);
    temperature = 16'h0191 ^ 16'(1 + $urandom_range(0, 16'hFFFE));
    sp[0] = 8'h91; sp[1] = 8'h01;
    fixCrc();
    busReset();
    readCheck("convRd");

    p0 = pulseCnt;
    temperature = 16'($urandom);
    busReset();
    wbyte(8'hCC);
    wbyte(8'h44);
    clks(300);
    busReset();
    clks(1200);
    check("abortPulse", pulseCnt, p0);
    readCheck("abortRd");

    busReset();
    wbyte(8'hCC);
    wbyte(8'hBE);
    for (int i = 0; i < 3; i++) begin
      rbit(b);
      check($sformatf("midBit%0d", i), b, sp[0][i]);
    end
    busReset();
    readCheck("midRd");

    busReset();
    wbyte(8'h33);
    lowSeen = 1'b0;
    watch = 1'b1;
    rbyte(v);
    clks(2);
    watch = 1'b0;
    check("deadRead", v, 8'hFF);
    check("deadQuiet", lowSeen, 0);
    check("deadIdle", busy, 0);

    badCmd = 8'($urandom);
    if (badCmd == 8'h44 || badCmd == 8'hBE || badCmd == 8'h4E)
      badCmd = 8'h00;
    busReset();
    wbyte(8'hCC);
    wbyte(badCmd);
    lowSeen = 1'b0;
    watch = 1'b1;
    rbyte(v);
    clks(2);
    watch = 1'b0;
    check("badFunc", v, 8'hFF);
    check("badQuiet", lowSeen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
